// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the K2 ALU and its sequential divider.
//   ALU_WIDTH   - default datapath width used by the ALU and the divider
//   div_state_t - divider controller states
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/alu_div_alu.sv
// alu_div_alu: ripple-carry add/subtract unit of the K2 ALU.
//   x, y  - W-bit operands
//   sub   - 0: sum = x + y, 1: sum = x - y (two's complement, x + ~y + 1)
//   sum   - W-bit result
//   carry - carry out; in subtract mode 1 means no borrow (x >= y unsigned)
module alu_div_alu #(
    parameter int W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0]   c;
    logic [W-1:0] y_eff;

    // The subtract setting inverts y and injects the +1 as the carry-in.
    assign c[0] = sub;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign y_eff[gi]  = y[gi] ^ sub;
            assign sum[gi]    = x[gi] ^ y_eff[gi] ^ c[gi];
            assign c[gi + 1]  = (x[gi] & y_eff[gi]) | (c[gi] & (x[gi] ^ y_eff[gi]));
        end
    endgenerate

    assign carry = c[W];

endmodule

// File: rtl/alu_div.sv
// alu_div: sequential restoring divider, one quotient bit per clock.
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   start       - request, accepted when not busy (IDLE or DONE)
//   a, b        - unsigned dividend / divisor, sampled on the accepting edge
//   busy        - high while iterating
//   done        - one-cycle pulse, results valid from this cycle
//   quotient    - registered quotient, held until the next completion
//   remainder   - registered remainder, held until the next completion
//   div_by_zero - set when the last completed operation had b == 0
module alu_div
    import alu_pkg::*;
#(
    parameter int N = ALU_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    div_state_t   state_reg;
    logic [N-1:0] p_reg;
    logic [N-1:0] q_reg;
    logic [N-1:0] d_reg;
    logic [CW-1:0] count_reg;
    logic [N-1:0] quotient_reg;
    logic [N-1:0] remainder_reg;
    logic         div_by_zero_reg;

    logic [N:0]   s;
    logic [N:0]   t;
    logic         alu_carry;
    logic         no_borrow;
    logic [N-1:0] p_next;
    logic [N-1:0] q_next;

    // Shift the next dividend bit into the partial remainder.
    assign s = {p_reg, q_reg[N-1]};

    alu_div_alu #(
        .W(N + 1)
    ) u_sub (
        .x    (s),
        .y    ({1'b0, d_reg}),
        .sub  (1'b1),
        .sum  (t),
        .carry(alu_carry)
    );

    // Because P < D always holds, S < 2D: with no borrow T < D leaves T[N]
    // clear, and with a borrow the wrapped T has T[N] set. Both views agree,
    // so folding in T[N] changes nothing and consumes the full ALU result.
    assign no_borrow = alu_carry & ~t[N];

    assign p_next = no_borrow ? t[N-1:0] : s[N-1:0];
    assign q_next = {q_reg[N-2:0], no_borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            p_reg           <= '0;
            q_reg           <= '0;
            d_reg           <= '0;
            count_reg       <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        if (b == '0) begin
                            // Divide by zero completes immediately.
                            quotient_reg    <= '1;
                            remainder_reg   <= a;
                            div_by_zero_reg <= 1'b1;
                            state_reg       <= DONE;
                        end else begin
                            p_reg     <= '0;
                            q_reg     <= a;
                            d_reg     <= b;
                            count_reg <= CW'(N - 1);
                            state_reg <= RUN;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    p_reg <= p_next;
                    q_reg <= q_next;
                    if (count_reg == '0) begin
                        quotient_reg    <= q_next;
                        remainder_reg   <= p_next;
                        div_by_zero_reg <= 1'b0;
                        state_reg       <= DONE;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_alu_div.sv
module tb_alu_div;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks_cnt = 0;
    int errors_cnt = 0;

    alu_div #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; start is sampled on the following posedge (E0)
    // and the task returns at the negedge after E0 (cycle 1).
    task automatic do_start(input logic [N-1:0] av, input logic [N-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits from cycle first_cycle until done is seen, returns at that negedge.
    task automatic wait_result(input string tag, input int first_cycle,
                               input int exp_q, input int exp_r, input int exp_dbz,
                               input int exp_lat);
        int cycles;
        int busy_cnt;
        cycles   = first_cycle;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, cycles, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat - first_cycle);
        check({tag, "_quotient"}, quotient, exp_q);
        check({tag, "_remainder"}, remainder, exp_r);
        check({tag, "_dbz"}, div_by_zero, exp_dbz);
        $display("op %s: q=%0d r=%0d dbz=%0d latency=%0d", tag, quotient, remainder,
                 div_by_zero, cycles);
    endtask

    task automatic run_op(input string tag, input int av, input int bv,
                          input int exp_q, input int exp_r, input int exp_dbz,
                          input int exp_lat);
        do_start(N'(av), N'(bv));
        wait_result(tag, 1, exp_q, exp_r, exp_dbz, exp_lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic expect_no_done(input string tag, input int ncycles);
        int dones;
        dones = 0;
        for (int i = 0; i < ncycles; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check({tag, "_no_done"}, dones, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);

        // Basic operations: b != 0 completes in N+1 cycles, b == 0 in one.
        run_op("100/7", 100, 7, 14, 2, 0, 9);
        run_op("5/9", 5, 9, 0, 5, 0, 9);
        run_op("255/1", 255, 1, 255, 0, 0, 9);
        run_op("255/255", 255, 255, 1, 0, 0, 9);
        run_op("37/0", 37, 0, 255, 37, 1, 1);
        run_op("dbz_clear", 20, 4, 5, 0, 0, 9);

        // Start during RUN is ignored.
        do_start(8'd100, 8'd7);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_result("ignored_start", 4, 14, 2, 0, 9);
        @(negedge clk);
        expect_no_done("ignored_start", 12);

        // Reset mid-RUN aborts the operation.
        do_start(8'd200, 8'd6);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        expect_no_done("abort", 12);
        run_op("200/6", 200, 6, 33, 2, 0, 9);

        // Back-to-back: start accepted during the done cycle.
        do_start(8'd100, 8'd7);
        wait_result("b2b_first", 1, 14, 2, 0, 9);
        start = 1'b1;
        a     = 8'd50;
        b     = 8'd5;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_one_cycle", done, 0);
        check("b2b_busy_rise", busy, 1);
        wait_result("b2b_second", 1, 10, 0, 0, 9);
        @(negedge clk);
        check("b2b_done_pulse", done, 0);

        // Random sweep against a reference model.
        for (int i = 0; i < 24; i++) begin
            int av;
            int bv;
            av = int'($urandom_range(0, 255));
            bv = (i % 6 == 5) ? 0 : int'($urandom_range(1, 255));
            if (bv == 0)
                run_op("rand", av, bv, 255, av, 1, 1);
            else
                run_op("rand", av, bv, av / bv, av % bv, 0, 9);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
